vending_fsm: RTL and testbench
==============================

// Module: vending_fsm
// PURPOSE
//  Coin-accumulating vending-machine controller; drink price 25 cents (5 nickel units).
//  - Samples one coin code per clock and accumulates credit.
//  - Asserts vend for one cycle when credit reaches or exceeds 25, and returns any excess as change.
//  - Sits between the coin-acceptor decoder and the dispenser/change-return actuators.
// PARAMETERS
//  PRICE   5   drink price in nickel units (5 = 25 cents); state encodings below assume 5
// PORTS
//  clock   in   1  single system clock; all state updates on its rising edge
//  reset   in   1  asynchronous, active-low reset (0 = reset asserted)
//  coin    in   3  coin code sampled each rising edge (see coin table)
//  vend    out  1  registered; 1 = dispense drink this cycle
//  state   out  3  registered; current credit state encoding
//  change  out  3  registered; change returned this cycle, in nickel units
// BEHAVIOUR
//  Coin table (value in nickels):
//  - 0 = none (0); 1 = NICKEL (1); 2 = DIME (2); 3 = NICKEL_DIME (3);
//  - 4 = DIME_DIME (4); 5 = QUARTER (5).
//  - Codes 6 and 7 are invalid and are treated as none (0); the coin is ignored and no credit is added.
//  States (credit in nickels):
//  - IDLE = 0 (0); FIVE = 1 (1); TEN = 2 (2); FIFTEEN = 3 (3); TWENTY = 4 (4);
//  - TWENTYFIVE = 5 (vend state; carries 0 credit forward).
//  Reset:
//  - While reset = 0, asynchronously: state = IDLE, vend = 0, change = 0.
//  - First coin is sampled on the first rising edge after reset returns to 1.
//  - Reset mid-accumulation discards all credit; no vend, no change is issued.
//  Per rising edge with reset = 1:
//  - base = 0 if state is IDLE or TWENTYFIVE, else the state's credit.
//  - total = base + coin value. Width rule: compute in 4 bits; maximum total is 4 + 5 = 9.
//  - If total >= 5: next state = TWENTYFIVE, vend = 1, change = total - 5 (range 0..4).
//  - Else: next state = encoding of total, vend = 0, change = 0.
//  Timing and outputs:
//  - Latency: the coin is sampled at edge N; state, vend and change reflect it immediately after edge N.
//  - vend and change are valid for exactly one cycle, while state = TWENTYFIVE.
//  - change = 0 in every non-vend cycle.
//  - Back-to-back vends are permitted: a QUARTER sampled while in TWENTYFIVE vends again with change 0.
//  - No handshake: a coin code held for k cycles counts as k coins; upstream must pulse one cycle per coin.
//  - Illegal state encodings 6 and 7 recover to IDLE on the next edge, with vend = 0 and change = 0.
// TESTING
//  1. reset = 0 pulse with coin = QUARTER held -> state = 0, vend = 0, change = 0 throughout reset.
//  2. From IDLE, NICKEL x5 -> state 1, 2, 3, 4, 5; vend = 1 only on the 5th edge, change = 0.
//  3. From IDLE, NICKEL, DIME, DIME -> state 1, 3, 5; vend = 1 on the 3rd edge, change = 0.
//  4. From IDLE, NICKEL, DIME, QUARTER -> state 1, 3, 5; vend = 1, change = 3 (15 cents).
//  5. From IDLE, NICKEL x4 then DIME -> state 4 then 5; vend = 1, change = 1.
//     Next edge with coin = 0 -> state 0, vend = 0, change = 0.
//  6. Invalid code 7 in state TEN -> state stays 2, no vend.
//     Then reset low mid-credit -> state 0; then QUARTER -> vend = 1, change = 0.

Source files
------------

// File: rtl/vending_fsm.sv
// rtl/vending_fsm.sv - coin-accumulating vending-machine controller
//
// Purpose: accumulates coin credit in nickel units and dispenses a drink once
// the credit reaches PRICE. Any excess is returned as change in the same cycle.
// Ports:
//   clock   in   1  system clock, rising-edge active
//   reset   in   1  asynchronous active-low reset
//   coin    in   3  coin code sampled every rising edge (6/7 ignored)
//   vend    out  1  registered, dispense pulse (one cycle, state = TWENTYFIVE)
//   state   out  3  registered, current credit state encoding
//   change  out  3  registered, change returned this cycle in nickels
module vending_fsm #(
   parameter int PRICE = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] coin,
   output logic       vend,
   output logic [2:0] state,
   output logic [2:0] change
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FIVE       = 3'd1,
      TEN        = 3'd2,
      FIFTEEN    = 3'd3,
      TWENTY     = 3'd4,
      TWENTYFIVE = 3'd5
   } state_t;

   state_t     state_q;
   logic [3:0] coin_val;
   logic [3:0] base;
   logic [3:0] total;
   logic       illegal;

   assign state = state_q;

   // Codes 6 and 7 decode to zero credit.
   always_comb begin
      coin_val = 4'd0;
      case (coin)
         3'd1, 3'd2, 3'd3, 3'd4, 3'd5: coin_val = {1'b0, coin};
         default:                      coin_val = 4'd0;
      endcase
   end

   // The vend state carries no credit forward, so it contributes like IDLE.
   always_comb begin
      base    = 4'd0;
      illegal = 1'b0;
      case (state_q)
         IDLE, TWENTYFIVE:           base = 4'd0;
         FIVE, TEN, FIFTEEN, TWENTY: base = {1'b0, state_q};
         default:                    illegal = 1'b1;
      endcase
      total = base + coin_val;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         vend    <= 1'b0;
         change  <= 3'd0;
      end else if (illegal) begin
         // Corrupted encodings drop any credit and restart cleanly.
         state_q <= IDLE;
         vend    <= 1'b0;
         change  <= 3'd0;
      end else if (total >= 4'(PRICE)) begin
         state_q <= TWENTYFIVE;
         vend    <= 1'b1;
         change  <= 3'(total - 4'(PRICE));
      end else begin
         state_q <= state_t'(total[2:0]);
         vend    <= 1'b0;
         change  <= 3'd0;
      end
   end

endmodule

// File: tb/tb_vending_fsm.sv
// tb/tb_vending_fsm.sv - randomized self-checking bench for vending_fsm
module tb_vending_fsm;

   logic       clock;
   logic       reset;
   logic [2:0] coin;
   logic       vend;
   logic [2:0] state;
   logic [2:0] change;

   int checks = 0;
   int errors = 0;

   // Reference model: credit held as a plain integer of nickels.
   int coin_value [8] = '{0, 1, 2, 3, 4, 5, 0, 0};
   int credit;
   int exp_state;
   int exp_vend;
   int exp_change;

   vending_fsm #(.PRICE(5)) dut (
      .clock  (clock),
      .reset  (reset),
      .coin   (coin),
      .vend   (vend),
      .state  (state),
      .change (change)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},  int'(state),  exp_state);
      check({tag, ".vend"},   int'(vend),   exp_vend);
      check({tag, ".change"}, int'(change), exp_change);
   endtask

   function automatic void model_reset();
      credit     = 0;
      exp_state  = 0;
      exp_vend   = 0;
      exp_change = 0;
   endfunction

   function automatic void model_coin(input int code);
      int sum;
      sum = credit + coin_value[code];
      if (sum >= 5) begin
         credit     = 0;
         exp_state  = 5;
         exp_vend   = 1;
         exp_change = sum - 5;
      end else begin
         credit     = sum;
         exp_state  = sum;
         exp_vend   = 0;
         exp_change = 0;
      end
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input int code, input string tag);
      coin = 3'(code);
      @(posedge clock);
      model_coin(code);
      #1;
      check_all(tag);
      @(negedge clock);
   endtask

   // Reset pulse spanning a rising edge with a QUARTER held on coin.
   task automatic pulse_reset(input string tag);
      coin  = 3'd5;
      reset = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".async"});
      @(posedge clock);
      #1;
      check_all({tag, ".held"});
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      coin  = 3'd0;
      model_reset();
      @(negedge clock);
      pulse_reset("rst0");

      // NICKEL x5
      for (int i = 0; i < 5; i++) apply(1, "nickel5");
      apply(0, "idle_a");
      // NICKEL, DIME, DIME
      apply(1, "ndd"); apply(2, "ndd"); apply(2, "ndd");
      apply(0, "idle_b");
      // NICKEL, DIME, QUARTER -> change 3
      apply(1, "ndq"); apply(2, "ndq"); apply(5, "ndq");
      apply(0, "idle_c");
      // NICKEL x4, DIME -> change 1, then idle
      for (int i = 0; i < 4; i++) apply(1, "n4d");
      apply(2, "n4d");
      apply(0, "n4d_after");
      // Invalid code in TEN, reset mid-credit, then QUARTER
      apply(2, "inv"); apply(7, "inv7"); apply(6, "inv6");
      pulse_reset("rst_mid");
      apply(5, "q_after_rst");
      // Back-to-back QUARTERs and DIME_DIME with maximum change
      apply(5, "qq"); apply(4, "dd"); apply(5, "max_change");

      // Randomized coins with occasional reset pulses
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset("rnd_rst");
         else apply(int'($urandom_range(0, 7)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
